usb_rx_byte_ctrl: RTL and testbench
===================================

USB_RX_BYTE_CTRL -- requirements
Module: usb_rx_byte_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h80; the value held by the LSB-first shift register after a valid SYNC.
REQ-002 SHALL have parameter STUFF_RUN, default 6; the run of consecutive 1s after which a stuffed 0 is expected.
REQ-003 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port bit_strobe, input, 1, one-cycle pulse per decoded bit.
REQ-006 SHALL have port d_bit, input, 1, decoded data bit, valid when bit_strobe=1.
REQ-007 SHALL have port eop, input, 1, one-cycle end-of-packet pulse.
REQ-008 SHALL have port rx_data, input, 8, parallel_out of the external serial-to-parallel register.
REQ-009 SHALL have port shift_enable, output, 1; pause, output, 1; both drive the external shift register.
REQ-010 SHALL have port rx_byte, output, 8; byte_ready, output, 1; rcving, output, 1; rx_err, output, 1.

Function
REQ-011 SHALL implement states IDLE, SYNC, DATA, ERR.
REQ-012 SHALL assert shift_enable combinationally as bit_strobe & (state==SYNC|DATA) & ~eop.
REQ-013 SHALL, in IDLE, on bit_strobe with d_bit=0, enter SYNC; this bit is shifted and counts as bit 0.
REQ-014 SHALL count shifted bits mod 8 with a 3-bit counter; paused (stuffed) bits are not counted.
REQ-015 SHALL, one cycle after the 8th SYNC bit shifts, compare rx_data to SYNC_BYTE: equal -> DATA, unequal -> ERR.
REQ-016 SHALL track consecutive strobed 1s; when the count equals STUFF_RUN and the next strobed bit is 0, assert pause with that shift_enable, not count the bit, and clear the run counter.
REQ-017 SHALL, in DATA, one cycle after the edge on which the 8th bit shifts, latch rx_byte<=rx_data and pulse byte_ready for exactly one cycle.
REQ-018 SHALL, on eop in DATA with bit counter 0, return to IDLE; with bit counter nonzero, enter ERR.
REQ-019 SHALL, on eop in SYNC, enter ERR; ERR SHALL hold until eop, then go to IDLE.
REQ-020 SHALL give eop priority over a simultaneous bit_strobe; that bit is neither shifted nor counted.
REQ-021 SHALL drive rcving=1 in SYNC and DATA; rx_err=1 in ERR.
REQ-022 SHALL ignore bit_strobe in ERR and IDLE (apart from REQ-013).

Reset
REQ-023 SHALL, while rst=1 at a clk edge, set state=IDLE, counters=0, rx_byte=8'h00, byte_ready=0, rcving=0, rx_err=0; mid-packet reset aborts with no byte_ready.

Configuration
REQ-024 SHALL, with RX_STUFF_CHK_EN defined, enter ERR when the bit after a STUFF_RUN run is 1; without it, that bit SHALL be shifted as data and the run counter cleared.

Structure
REQ-025 SHALL place the state enum and the SYNC_BYTE/STUFF_RUN defaults in package usb_rx_pkg.
REQ-026 SHALL implement the ones-run counter and stuff decision as sub-module usb_stuff_cnt.

Verification
REQ-027 SHALL test: bits 0,0,0,0,0,0,0,1 with rx_data=8'h80, then 8 bits of 8'hA5 -> DATA; byte_ready pulses once with rx_byte=8'hA5.
REQ-028 SHALL test: data 1,1,1,1,1,1 then 0 -> pause=1 on the 0; the next 8 real bits still yield one byte_ready.
REQ-029 SHALL test: six 1s then 1 -> rx_err=1 with RX_STUFF_CHK_EN defined, no error without it.
REQ-030 SHALL test: SYNC leaving rx_data=8'h81 -> ERR; eop -> IDLE, rx_err=0.
REQ-031 SHALL test: eop after 3 data bits -> ERR; eop coincident with bit_strobe -> shift_enable=0.
REQ-032 SHALL test: rst mid-DATA -> all outputs at reset values next cycle, no byte_ready.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg -- shared types and defaults for the USB receive byte controller.
//   rx_state_t        : controller states IDLE / SYNC / DATA / ERR
//   SYNC_BYTE_DEFAULT : value of the LSB-first shift register after a good SYNC
//   STUFF_RUN_DEFAULT : run of 1s after which a stuffed 0 is expected
//   is_receiving()    : true in the states that accept packet bits
package usb_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;
  localparam int         STUFF_RUN_DEFAULT = 6;

  function automatic logic is_receiving(input rx_state_t s);
    return (s == ST_SYNC) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/usb_stuff_cnt.sv
// usb_stuff_cnt -- consecutive-ones run counter and bit-stuffing decision.
// Optional feature macro: RX_STUFF_CHK_EN (a 1 following a full run is an error).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : hold the run counter at zero (controller not receiving)
//   bit_valid  : a bit is being taken this cycle (d_bit is meaningful)
//   d_bit      : the bit being taken
//   stuff_bit  : the current bit is the stuffed 0 after a full run
//   stuff_err  : the current bit is a 1 after a full run (only with RX_STUFF_CHK_EN)
module usb_stuff_cnt
  import usb_rx_pkg::*;
#(
  parameter int STUFF_RUN = STUFF_RUN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_valid,
  input  logic d_bit,
  output logic stuff_bit,
  output logic stuff_err
);

  localparam int               RUN_W   = $clog2(STUFF_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_RUN);

  logic [RUN_W-1:0] run_cnt;
  logic             run_full;

  assign run_full  = (run_cnt == RUN_MAX);
  assign stuff_bit = run_full & ~d_bit;
`ifdef RX_STUFF_CHK_EN
  assign stuff_err = run_full & d_bit;
`else
  assign stuff_err = 1'b0;
`endif

  // Run-length register: the bit that follows a full run (stuffed 0, or a 1
  // taken as data / flagged as error) always restarts the run at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= {RUN_W{1'b0}};
    end else if (clr) begin
      run_cnt <= {RUN_W{1'b0}};
    end else if (bit_valid) begin
      if (run_full || !d_bit) begin
        run_cnt <= {RUN_W{1'b0}};
      end else begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end else begin
      run_cnt <= run_cnt;
    end
  end

endmodule

// File: rtl/usb_rx_byte_ctrl.sv
// usb_rx_byte_ctrl -- controls an external LSB-first serial-to-parallel register
// for a USB receiver: detects SYNC, counts bits, strips stuffed bits and hands
// out whole bytes.
// Optional feature macro: RX_STUFF_CHK_EN (a 1 after a full run of 1s -> ERR).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bit_strobe    : one-cycle pulse per decoded bit; d_bit valid with it
//   eop           : one-cycle end-of-packet pulse (wins over bit_strobe)
//   rx_data       : parallel output of the external shift register
//   shift_enable  : shift the external register this cycle
//   pause         : current bit is stuffed; external register must not take it
//   rx_byte       : last received data byte; byte_ready pulses when it updates
//   rcving        : in SYNC or DATA
//   rx_err        : in ERR (held until eop)
module usb_rx_byte_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         STUFF_RUN = STUFF_RUN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_strobe,
  input  logic       d_bit,
  input  logic       eop,
  input  logic [7:0] rx_data,
  output logic       shift_enable,
  output logic       pause,
  output logic [7:0] rx_byte,
  output logic       byte_ready,
  output logic       rcving,
  output logic       rx_err
);

  rx_state_t  state;
  rx_state_t  state_next;
  logic [2:0] bit_cnt;
  logic       sync_done;
  logic       data_done;
  logic       receiving;
  logic       start_bit;
  logic       stuff_bit;
  logic       stuff_one;
  logic       stuff_err;
  logic       count_bit;
  logic       last_bit;

  assign receiving = is_receiving(state);
  // The leading 0 that starts a packet in IDLE is already SYNC bit 0, so it
  // has to reach the external register as well.
  assign start_bit    = (state == ST_IDLE) & ~d_bit;
  assign shift_enable = bit_strobe & ~eop & (receiving | start_bit);
  assign pause        = shift_enable & receiving & stuff_bit;
  assign stuff_err    = shift_enable & receiving & stuff_one;
  assign count_bit    = shift_enable & ~pause & ~stuff_err;
  assign last_bit     = count_bit & (bit_cnt == 3'd7);

  assign rcving = receiving;
  assign rx_err = (state == ST_ERR);

  usb_stuff_cnt #(
    .STUFF_RUN(STUFF_RUN)
  ) u_stuff (
    .clk      (clk),
    .rst      (rst),
    .clr      (~receiving),
    .bit_valid(shift_enable),
    .d_bit    (d_bit),
    .stuff_bit(stuff_bit),
    .stuff_err(stuff_one)
  );

  // Next-state logic; eop outranks everything else in every state.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bit_strobe && !eop && start_bit) begin
          state_next = ST_SYNC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (eop || stuff_err) begin
          state_next = ST_ERR;
        end else if (sync_done) begin
          // rx_data has held the complete SYNC pattern since the previous edge
          state_next = (rx_data == SYNC_BYTE) ? ST_DATA : ST_ERR;
        end else begin
          state_next = ST_SYNC;
        end
      end
      ST_DATA: begin
        if (eop) begin
          state_next = (bit_cnt == 3'd0) ? ST_IDLE : ST_ERR;
        end else if (stuff_err) begin
          state_next = ST_ERR;
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_ERR: begin
        if (eop) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_ERR;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bit-within-byte counter; stuffed bits are skipped, ERR and IDLE clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
    end else if (state == ST_ERR) begin
      bit_cnt <= 3'd0;
    end else if (count_bit) begin
      bit_cnt <= bit_cnt + 3'd1;
    end else if (state == ST_IDLE) begin
      bit_cnt <= 3'd0;
    end else begin
      bit_cnt <= bit_cnt;
    end
  end

  // Remember that the 8th bit just shifted; rx_data is complete one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_done <= 1'b0;
      data_done <= 1'b0;
    end else begin
      sync_done <= last_bit & (state == ST_SYNC);
      data_done <= last_bit & (state == ST_DATA);
    end
  end

  // Byte hand-off register and its one-cycle ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte    <= 8'h00;
      byte_ready <= 1'b0;
    end else begin
      byte_ready <= data_done;
      if (data_done) begin
        rx_byte <= rx_data;
      end else begin
        rx_byte <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_byte_ctrl.sv
// tb_usb_rx_byte_ctrl -- self-checking bench for usb_rx_byte_ctrl.
// A packet-level reference model (phase, real-bit count, ones run, external
// shift register) predicts every output; a negedge process compares each cycle.
// Directed scenarios pin the model with literal values; random packets follow.
module tb_usb_rx_byte_ctrl;

  localparam int STUFF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_strobe;
  logic       d_bit;
  logic       eop;
  logic [7:0] rx_data;
  logic       shift_enable;
  logic       pause;
  logic [7:0] rx_byte;
  logic       byte_ready;
  logic       rcving;
  logic       rx_err;

  usb_rx_byte_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bit_strobe  (bit_strobe),
    .d_bit       (d_bit),
    .eop         (eop),
    .rx_data     (rx_data),
    .shift_enable(shift_enable),
    .pause       (pause),
    .rx_byte     (rx_byte),
    .byte_ready  (byte_ready),
    .rcving      (rcving),
    .rx_err      (rx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 sync, 2 data, 3 error.
  int         phase = 0;
  int         nbits = 0;     // real (unstuffed) bits in this packet
  int         ones = 0;      // current run of 1s
  bit         pend_s = 1'b0;
  bit         pend_d = 1'b0;
  logic [7:0] ext = 8'h00;   // external serial-to-parallel register
  logic [7:0] m_rx_byte = 8'h00;
  bit         m_br = 1'b0;
  bit         ovr_en = 1'b0; // force rx_data to 8'h81
  bit         chk_on = 1'b0;
  int         br_seen = 0;

  function automatic bit m_se(bit bs, bit db, bit ep);
    return bs && !ep && ((phase == 1) || (phase == 2) || (phase == 0 && !db));
  endfunction

  function automatic bit m_pause(bit bs, bit db, bit ep);
    return m_se(bs, db, ep) && (phase == 1 || phase == 2) && (ones == STUFF) && !db;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("shift_enable", {7'd0, shift_enable}, {7'd0, m_se(bit_strobe, d_bit, eop)});
      check("pause", {7'd0, pause}, {7'd0, m_pause(bit_strobe, d_bit, eop)});
      check("rcving", {7'd0, rcving}, {7'd0, (phase == 1 || phase == 2)});
      check("rx_err", {7'd0, rx_err}, {7'd0, (phase == 3)});
      check("byte_ready", {7'd0, byte_ready}, {7'd0, m_br});
      check("rx_byte", rx_byte, m_rx_byte);
      if (byte_ready === 1'b1) br_seen++;
    end
  end

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit bs, db, ep, r, se, ps, psync, counted;
    bs = bit_strobe; db = d_bit; ep = eop; r = rst; counted = 1'b0;
    if (r) begin
      phase = 0; nbits = 0; ones = 0; pend_s = 1'b0; pend_d = 1'b0;
      m_br = 1'b0; m_rx_byte = 8'h00;
    end else begin
      se = m_se(bs, db, ep);
      ps = m_pause(bs, db, ep);
      m_br = pend_d;
      if (pend_d) m_rx_byte = rx_data;
      psync = pend_s;
      pend_s = 1'b0;
      pend_d = 1'b0;
      if (ep) begin
        if (phase == 1) phase = 3;
        else if (phase == 2) phase = (nbits % 8 == 0) ? 0 : 3;
        else if (phase == 3) phase = 0;
      end else if (psync && phase == 1) begin
        phase = (rx_data == 8'h80) ? 2 : 3;
      end else if (se) begin
        if (phase == 0) begin
          phase = 1; nbits = 1; ones = 0;
        end else if (ones == STUFF && !db) begin
          ones = 0;
        end else if (ones == STUFF && db) begin
`ifdef RX_STUFF_CHK_EN
          phase = 3;
`else
          nbits++; ones = 0; counted = 1'b1;
`endif
        end else begin
          nbits++; ones = db ? ones + 1 : 0; counted = 1'b1;
        end
        if (counted && nbits % 8 == 0) begin
          if (phase == 1) pend_s = 1'b1;
          else pend_d = 1'b1;
        end
      end
      if (phase == 0 || phase == 3) begin
        nbits = 0; ones = 0;
      end
      if (se && !ps) ext = {db, ext[7:1]};
    end
    rx_data = ovr_en ? 8'h81 : ext;
  endtask

  task automatic cyc(bit bs, bit db, bit ep, bit r);
    bit_strobe = bs; d_bit = db; eop = ep; rst = r;
    @(posedge clk);
    #1;
    model_edge();
    bit_strobe = 1'b0; d_bit = 1'b0; eop = 1'b0; rst = 1'b0;
  endtask

  task automatic send_bit(bit b);
    cyc(1'b1, b, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_eop();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_sync();
    send_byte(8'h80);
  endtask

  // Drive a bit with optional eop, sample one output mid-cycle against a literal.
  task automatic strobe_and_pin(bit db, bit ep, string name, bit use_pause, bit exp);
    bit_strobe = 1'b1; d_bit = db; eop = ep;
    #2;
    if (use_pause) check(name, {7'd0, pause}, {7'd0, exp});
    else check(name, {7'd0, shift_enable}, {7'd0, exp});
    @(posedge clk);
    #1;
    model_edge();
    bit_strobe = 1'b0; d_bit = 1'b0; eop = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n, base, j;
    logic [7:0] sync_pat;
    rst = 1'b1; bit_strobe = 1'b0; d_bit = 1'b0; eop = 1'b0; rx_data = 8'h00;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_on = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_rcving", {7'd0, rcving}, 8'h00);
    check("reset_rx_err", {7'd0, rx_err}, 8'h00);
    check("reset_byte_ready", {7'd0, byte_ready}, 8'h00);
    check("reset_rx_byte", rx_byte, 8'h00);

    // Good SYNC then one data byte.
    base = br_seen;
    send_bit(1'b1);                         // ignored in idle
    check("idle_ignores_one", {7'd0, rcving}, 8'h00);
    send_sync();
    check("sync_ok_rcving", {7'd0, rcving}, 8'h01);
    check("sync_ok_no_err", {7'd0, rx_err}, 8'h00);
    send_byte(8'hA5);
    check("byte_a5", rx_byte, 8'hA5);
    check("byte_a5_once", br_seen - base, 1);
    send_eop();
    check("eop_to_idle", {7'd0, rcving}, 8'h00);

    // Stuffed zero after six 1s is paused and not counted.
    send_sync();
    base = br_seen;
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    strobe_and_pin(1'b0, 1'b0, "stuff_pause", 1'b1, 1'b1);
    check("stuff_no_byte_yet", br_seen - base, 0);
    send_bit(1'b0);
    check("stuff_byte_7e", rx_byte, 8'h7E);
    check("stuff_byte_once", br_seen - base, 1);
    send_eop();

    // Six 1s followed by another 1.
    send_sync();
    base = br_seen;
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b1);
`ifdef RX_STUFF_CHK_EN
    check("stuff_violation_err", {7'd0, rx_err}, 8'h01);
    check("stuff_violation_nobyte", br_seen - base, 0);
`else
    check("stuff_violation_noerr", {7'd0, rx_err}, 8'h00);
    check("stuff_violation_byte", rx_byte, 8'hFE);
`endif
    send_eop();
    check("after_violation_idle", {7'd0, rx_err | rcving}, 8'h00);

    // Bad SYNC pattern.
    ovr_en = 1'b1;
    send_sync();
    check("bad_sync_err", {7'd0, rx_err}, 8'h01);
    ovr_en = 1'b0;
    send_eop();
    check("bad_sync_clear", {7'd0, rx_err}, 8'h00);
    check("bad_sync_idle", {7'd0, rcving}, 8'h00);

    // eop after 3 data bits, then eop coincident with a strobe.
    send_sync();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_eop();
    check("partial_byte_err", {7'd0, rx_err}, 8'h01);
    send_eop();
    check("err_eop_clear", {7'd0, rx_err}, 8'h00);
    send_sync();
    strobe_and_pin(1'b1, 1'b1, "eop_beats_strobe", 1'b0, 1'b0);
    check("eop_strobe_idle", {7'd0, rcving | rx_err}, 8'h00);

    // Reset in the cycle the byte would be handed out.
    send_sync();
    base = br_seen;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_rcving", {7'd0, rcving}, 8'h00);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_byte_ready", {7'd0, byte_ready}, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_no_byte", br_seen - base, 0);

    // Random packets.
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) send_bit(1'b1);
      sync_pat = 8'h80;
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(1, 7);
        sync_pat[j] = ~sync_pat[j];
      end
      send_byte(sync_pat);
      n = $urandom_range(0, 30);
      for (int i = 0; i < n; i++) send_bit($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      send_eop();
      send_eop();
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
